// File: rtl/spi_master.sv
// SPI master for a byte-addressed memory: 16-bit frame of command {addr,rw} then data, mode 0, MSB first.
// Optional completed-frame counter is built only when SPI_MASTER_COUNT_EN is defined.
module spi_master #(
    parameter int CLKDIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin,
    output logic [7:0] xfer_count
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

    state_t      state;
    logic [7:0]  half_cnt;
    logic [4:0]  bit_cnt;
    logic [14:0] tx_shift;
    logic [7:0]  rx_shift;
    logic        rw_latched;

    // tx_shift holds frame bits 2..16; bit 1 goes straight onto mosi_pin when the frame is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            half_cnt   <= 8'd0;
            bit_cnt    <= 5'd0;
            tx_shift   <= 15'd0;
            rx_shift   <= 8'd0;
            rw_latched <= 1'b0;
            rdata      <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            sclk_pin   <= 1'b0;
            cs_pin     <= 1'b1;
            mosi_pin   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift   <= {addr[5:0], rw, (rw ? 8'h00 : wdata)};
                        mosi_pin   <= addr[6];
                        rw_latched <= rw;
                        cs_pin     <= 1'b0;
                        busy       <= 1'b1;
                        half_cnt   <= RELOAD;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (half_cnt == 8'd0) begin
                        sclk_pin <= 1'b1;
                        half_cnt <= RELOAD;
                        bit_cnt  <= 5'd0;
                        state    <= SHIFT;
                    end else begin
                        half_cnt <= half_cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (half_cnt == 8'd0) begin
                        half_cnt <= RELOAD;
                        if (sclk_pin) begin
                            sclk_pin <= 1'b0;
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15) begin
                                mosi_pin <= 1'b0;
                                state    <= HOLD;
                            end else begin
                                mosi_pin <= tx_shift[14];
                                tx_shift <= {tx_shift[13:0], 1'b0};
                            end
                        end else begin
                            // bit_cnt counts completed falls, so rises 9..16 see 8..15
                            sclk_pin <= 1'b1;
                            if (rw_latched && bit_cnt >= 5'd8)
                                rx_shift <= {rx_shift[6:0], miso_pin};
                        end
                    end else begin
                        half_cnt <= half_cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (half_cnt == 8'd0) begin
                        cs_pin   <= 1'b1;
                        done     <= 1'b1;
                        half_cnt <= RELOAD;
                        if (rw_latched)
                            rdata <= rx_shift;
                        state <= GAP;
                    end else begin
                        half_cnt <= half_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (half_cnt == 8'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        half_cnt <= half_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_MASTER_COUNT_EN
    // Counts on the cycle after each done pulse and wraps naturally at 8 bits
    always_ff @(posedge clk) begin
        if (reset)
            xfer_count <= 8'h00;
        else if (done)
            xfer_count <= xfer_count + 8'h01;
    end
`else
    assign xfer_count = 8'h00;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master with CLKDIV=4 (frame = 137 cycles start-to-idle).
// Expected xfer_count follows SPI_MASTER_COUNT_EN, so the bench must see the same define as the RTL.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset, start, rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata, xfer_count;
    logic       busy, done, sclk_pin, cs_pin, mosi_pin;
    logic       miso_pin = 1'b0;

    int total = 0;
    int bad   = 0;

`ifdef SPI_MASTER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic [7:0]  slave_byte = 8'h00;
    int          falls = 0;
    logic [15:0] mosi_cap;
    int          dones, done_at, busy_fall, viol, cs_bad, cnt_bad;
    logic [7:0]  exp_cnt;

    always #5 clk = ~clk;

    spi_master #(.CLKDIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .mosi_pin(mosi_pin), .miso_pin(miso_pin), .xfer_count(xfer_count)
    );

    // Slave model: presents slave_byte MSB first, changing on SCLK falls 8..15
    always @(negedge sclk_pin or posedge cs_pin) begin
        if (cs_pin) begin
            falls    = 0;
            miso_pin = 1'b0;
        end else begin
            falls = falls + 1;
            if (falls >= 8 && falls <= 15)
                miso_pin = slave_byte[15 - falls];
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one frame at cycle T and observes cycles T+1..T+137
    task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] wd,
                             input int restart_at, input bit hold);
        logic prev_sclk, prev_mosi;
        @(negedge clk);
        rw = r; addr = a; wdata = wd; start = 1'b1;
        mosi_cap = 16'h0; dones = 0; done_at = 0; busy_fall = 0; viol = 0; cs_bad = 0;
        prev_sclk = 1'b0; prev_mosi = 1'b0;
        for (int c = 1; c <= 137; c++) begin
            @(negedge clk);
            if (!hold) begin
                start = (c == restart_at);
                if (c == restart_at) begin
                    rw = ~r; addr = ~a; wdata = ~wd;
                end
            end
            if (sclk_pin && !prev_sclk)
                mosi_cap = {mosi_cap[14:0], mosi_pin};
            if (c > 1 && mosi_pin !== prev_mosi && !(prev_sclk && !sclk_pin))
                viol++;
            if (done) begin
                dones++;
                if (done_at == 0) done_at = c;
            end
            if (!busy && busy_fall == 0) busy_fall = c;
            if ((c <= 132 && cs_pin !== 1'b0) || (c == 133 && cs_pin !== 1'b1))
                cs_bad++;
            prev_sclk = sclk_pin;
            prev_mosi = mosi_pin;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 7'h0; wdata = 8'h0;
        repeat (2) @(negedge clk);
        check_output("rst_cs", cs_pin, 1'b1);
        check_output("rst_sclk", sclk_pin, 1'b0);
        check_output("rst_mosi", mosi_pin, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_rdata", rdata, 8'h00);
        check_output("rst_count", xfer_count, 8'h00);
        reset = 1'b0;

        // Write 0x15 <- 0xA5
        run_frame(1'b0, 7'h15, 8'hA5, 0, 1'b0);
        check_output("wr_mosi", mosi_cap, 16'h2AA5);
        check_output("wr_dones", dones, 1);
        check_output("wr_done_at", done_at, 133);
        check_output("wr_busy_fall", busy_fall, 137);
        check_output("wr_mosi_timing", viol, 0);
        check_output("wr_cs", cs_bad, 0);
        check_output("wr_rdata", rdata, 8'h00);

        // Read 0x15, slave returns 0x3C
        slave_byte = 8'h3C;
        run_frame(1'b1, 7'h15, 8'hFF, 0, 1'b0);
        check_output("rd_mosi", mosi_cap, 16'h2B00);
        check_output("rd_dones", dones, 1);
        check_output("rd_done_at", done_at, 133);
        check_output("rd_rdata", rdata, 8'h3C);
        check_output("rd_mosi_timing", viol, 0);

        // Second start at T+10 with different operands must be ignored
        run_frame(1'b0, 7'h15, 8'hA5, 10, 1'b0);
        check_output("ign_mosi", mosi_cap, 16'h2AA5);
        check_output("ign_dones", dones, 1);
        check_output("ign_busy_fall", busy_fall, 137);
        check_output("ign_rdata", rdata, 8'h3C);
        check_output("ign_count", xfer_count, CNT_EN ? 8'd3 : 8'd0);

        // reset and start together: start is discarded
        @(negedge clk);
        reset = 1'b1; start = 1'b1; rw = 1'b0; addr = 7'h15; wdata = 8'hA5;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check_output("rs_busy", busy, 1'b0);
        check_output("rs_cs", cs_pin, 1'b1);
        @(negedge clk);
        check_output("rs_busy_later", busy, 1'b0);

        // Abort with reset on SCLK rise 5 (cycle T+37)
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (35) @(negedge clk);
        check_output("ab_sclk_t36", sclk_pin, 1'b0);
        @(negedge clk);
        check_output("ab_sclk_t37", sclk_pin, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("ab_cs", cs_pin, 1'b1);
        check_output("ab_sclk", sclk_pin, 1'b0);
        check_output("ab_busy", busy, 1'b0);
        check_output("ab_done", done, 1'b0);
        dones = 0;
        repeat (140) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_output("ab_no_done", dones, 0);
        check_output("ab_count", xfer_count, 8'h00);

        slave_byte = 8'hC3;
        run_frame(1'b1, 7'h40, 8'h00, 0, 1'b0);
        check_output("ab_rd_mosi", mosi_cap, 16'h8100);
        check_output("ab_rd_done_at", done_at, 133);
        check_output("ab_rd_rdata", rdata, 8'hC3);

        // Back-to-back with start held high
        run_frame(1'b0, 7'h01, 8'h3C, 0, 1'b1);
        check_output("b2b_mosi", mosi_cap, 16'h023C);
        check_output("b2b_done_at", done_at, 133);
        check_output("b2b_busy_fall", busy_fall, 137);
        @(negedge clk);
        start = 1'b0;
        check_output("b2b_cs_t138", cs_pin, 1'b0);
        check_output("b2b_busy_t138", busy, 1'b1);
        dones = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (!busy) break;
        end
        check_output("b2b_second_done", dones, 1);
        check_output("b2b_idle", busy, 1'b0);
        check_output("b2b_count", xfer_count, CNT_EN ? 8'd3 : 8'd0);

        // 257 frames from a fresh reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cnt_bad = 0;
        exp_cnt = 8'h00;
        for (int i = 0; i < 257; i++) begin
            run_frame(1'b0, 7'(i), 8'(i), 0, 1'b0);
            if (CNT_EN) exp_cnt = exp_cnt + 8'h01;
            if (xfer_count !== exp_cnt || dones != 1) cnt_bad++;
        end
        check_output("cnt_track", cnt_bad, 0);
        check_output("cnt_final", xfer_count, CNT_EN ? 8'h01 : 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLKDIV, default 16, meaning clk cycles per SCLK half-period (D); legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a frame.
REQ-005 SHALL have port rw  input  1  1 = read, 0 = write; sampled with start.
REQ-006 SHALL have port addr  input  7  target memory address; sampled with start.
REQ-007 SHALL have port wdata  input  8  write data; sampled with start.
REQ-008 SHALL have port rdata  output  8  last read byte.
REQ-009 SHALL have port busy  output  1  frame or inter-frame gap in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have ports sclk_pin output 1, cs_pin output 1, mosi_pin output 1, miso_pin input 1 (SPI bus, active-low chip select).
REQ-012 SHALL have port xfer_count  output  8  completed-frame counter (see Configuration).

Function
REQ-013 SHALL implement states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-014 In IDLE with start=1 at cycle T, SHALL latch {addr,rw,wdata}, enter SETUP; cs_pin=0, busy=1 from T+1.
REQ-015 start while busy=1 SHALL be ignored; latched operands SHALL not change.
REQ-016 SETUP SHALL last D cycles with sclk_pin=0 and mosi_pin = bit 7 of command byte {addr[6:0], rw}.
REQ-017 SHIFT SHALL produce 16 SCLK periods, each D cycles high then D cycles low; first rise at T+1+D.
REQ-018 Bits SHALL be sent MSB first; mosi_pin SHALL change only on the clk cycle where sclk_pin falls (next bit), never while sclk_pin high.
REQ-019 Bits 1-8 SHALL be the command byte; bits 9-16 SHALL be wdata for writes, constant 0 for reads.
REQ-020 For reads, miso_pin SHALL be sampled on the clk cycle of SCLK rising edges 9-16, shifted MSB first.
REQ-021 rdata SHALL update only at the end of a read frame; write frames SHALL leave it unchanged.
REQ-022 HOLD SHALL last D cycles after the 16th falling edge (sclk_pin=0), then cs_pin=1 and done=1 for one cycle at T+1+33D.
REQ-023 GAP SHALL hold cs_pin=1 for D cycles; busy SHALL fall at T+1+34D; start is accepted that cycle.
REQ-024 Idle bus levels SHALL be cs_pin=1, sclk_pin=0, mosi_pin=0.
REQ-025 Half-period counter SHALL be ceil(log2(256)) = 8 bits wide, reloading at D-1; bit counter 5 bits, 0..16.

Reset
REQ-026 reset=1 SHALL on the next clk edge force IDLE, cs_pin=1, sclk_pin=0, mosi_pin=0, busy=0, done=0, rdata=0x00, xfer_count=0x00.
REQ-027 reset mid-frame SHALL abort without a done pulse and without updating rdata or xfer_count.
REQ-028 reset and start asserted together SHALL leave the block in IDLE; start is discarded.

Configuration
REQ-029 With SPI_MASTER_COUNT_EN defined, xfer_count SHALL increment (wrap 0xFF -> 0x00) on each done pulse.
REQ-030 With SPI_MASTER_COUNT_EN undefined, xfer_count SHALL be constant 0x00 and no counter logic SHALL be built.

Verification
REQ-031 D=4, write addr=0x15 wdata=0xA5 -> mosi bits at SCLK rises = 0x2A then 0xA5; rdata stays 0x00; done at T+133.
REQ-032 D=4, read addr=0x15, slave model drives 0x3C on falling edges 8-15 -> command byte 0x2B, mosi 0 in byte 2, rdata=0x3C after done.
REQ-033 start pulsed again at T+10 during a frame -> frame unchanged, exactly one done, busy falls at T+137.
REQ-034 reset at sclk rise 5 -> next cycle cs_pin=1, sclk_pin=0, busy=0; no done; new start then completes normally.
REQ-035 Back-to-back: start held high from T -> second frame begins at T+137 (cs_pin low again), both done pulses seen.
REQ-036 With SPI_MASTER_COUNT_EN, 257 frames -> xfer_count=0x01; without it -> xfer_count=0x00 throughout.
